// File: rtl/axil_initiator.sv
// AXI4-Lite single-outstanding initiator: valid/ready request in, AXI4-Lite transaction out, response back.
// Optional watchdog abort for hung slaves is compiled in with `define AXIL_INITIATOR_TIMEOUT_EN.
module axil_initiator #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WADDR = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RADDR = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_RSP   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_resp_q, rsp_resp_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic        awvalid_q, awvalid_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic [31:0] araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        aw_done, w_done;

`ifdef AXIL_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             busy;
`endif

  // A channel counts as done once its valid has dropped or it handshakes this cycle.
  assign aw_done = !awvalid_q || m_axi_awready;
  assign w_done  = !wvalid_q  || m_axi_wready;

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
`ifdef AXIL_INITIATOR_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
    busy          = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_ready_d = 1'b0;
          rsp_write_d = req_write;
`ifdef AXIL_INITIATOR_TIMEOUT_EN
          cnt_d         = '0;
          rsp_timeout_d = 1'b0;
`endif
          if (req_write) begin
            awaddr_d  = req_addr;
            wdata_d   = req_wdata;
            wstrb_d   = req_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WADDR;
          end else begin
            araddr_d  = req_addr;
            arvalid_d = 1'b1;
            state_d   = S_RADDR;
          end
        end
      end
      S_WADDR: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end
      S_WRESP: begin
        if (m_axi_bvalid) begin
          bready_d    = 1'b0;
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
      end
      S_RADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (m_axi_rvalid) begin
          rready_d    = 1'b0;
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
`ifdef AXIL_INITIATOR_TIMEOUT_EN
    busy = (state_q == S_WADDR) || (state_q == S_WRESP) ||
           (state_q == S_RADDR) || (state_q == S_RDATA);
    if (busy) begin
      cnt_d = cnt_q + CNT_W'(1);
      // Watchdog wins over any handshake landing on the same edge: the slave is abandoned.
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        awvalid_d     = 1'b0;
        wvalid_d      = 1'b0;
        bready_d      = 1'b0;
        arvalid_d     = 1'b0;
        rready_d      = 1'b0;
        rsp_resp_d    = 2'b10;
        rsp_rdata_d   = '0;
        rsp_timeout_d = 1'b1;
        rsp_valid_d   = 1'b1;
        state_d       = S_RSP;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
    end
  end

`ifdef AXIL_INITIATOR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_initiator.sv
// Directed bench for axil_initiator: vector table of single transactions against a 256-word slave model,
// plus hand-written sequences for split write channels, response backpressure, reset and watchdog.
module tb_axil_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  axil_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Slave model state and knobs
  logic [31:0] mem [256];
  int          aw_dly = 1, w_dly = 1, ar_dly = 1;
  logic        ar_stall = 1'b0, b_hold = 1'b0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  int          aw_cnt, w_cnt, ar_cnt, wr_count, aw_hi, w_hi, ar_hi;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [31:0] s_awaddr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  slv_resp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic slave_clear();
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
    s_awaddr = '0; s_wdata = '0; s_rdata = '0; s_wstrb = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
  endtask

  // One clock: note handshakes before the edge, then let the slave react just after it.
  task automatic tick();
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [31:0] awa, wd, ara;
    logic [3:0] ws;
    aw_hs = m_axi_awvalid & m_axi_awready;
    w_hs  = m_axi_wvalid & m_axi_wready;
    b_hs  = m_axi_bvalid & m_axi_bready;
    ar_hs = m_axi_arvalid & m_axi_arready;
    r_hs  = m_axi_rvalid & m_axi_rready;
    awa = m_axi_awaddr; wd = m_axi_wdata; ws = m_axi_wstrb; ara = m_axi_araddr;
    if (m_axi_awvalid) aw_hi++;
    if (m_axi_wvalid)  w_hi++;
    if (m_axi_arvalid) ar_hi++;
    @(posedge clk);
    #1;
    if (rst) begin
      slave_clear();
      return;
    end
    if (aw_hs) begin aw_got = 1'b1; s_awaddr = awa; end
    if (w_hs)  begin w_got = 1'b1; s_wdata = wd; s_wstrb = ws; end
    if (b_hs)  b_pend = 1'b0;
    if (aw_got && w_got) begin
      for (int b = 0; b < 4; b++)
        if (s_wstrb[b]) mem[s_awaddr[9:2]][8*b +: 8] = s_wdata[8*b +: 8];
      wr_count++;
      aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1;
    end
    if (r_hs) r_pend = 1'b0;
    if (ar_hs) begin r_pend = 1'b1; s_rdata = mem[ara[9:2]]; end
    if (m_axi_awvalid) begin aw_cnt++; m_axi_awready = (aw_cnt >= aw_dly); end
    else begin aw_cnt = 0; m_axi_awready = 1'b0; end
    if (m_axi_wvalid) begin w_cnt++; m_axi_wready = (w_cnt >= w_dly); end
    else begin w_cnt = 0; m_axi_wready = 1'b0; end
    if (m_axi_arvalid && !ar_stall) begin ar_cnt++; m_axi_arready = (ar_cnt >= ar_dly); end
    else begin ar_cnt = 0; m_axi_arready = 1'b0; end
    m_axi_bvalid = b_pend && !b_hold;
    m_axi_bresp  = b_resp_cfg;
    m_axi_rvalid = r_pend;
    m_axi_rdata  = r_pend ? s_rdata : 32'h0;
    m_axi_rresp  = r_resp_cfg;
  endtask

  // Issue one request, wait for its response, optionally hold off rsp_ready for 'hold' cycles.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int hold, output int lat,
                        output logic [31:0] rdata, output logic [1:0] resp,
                        output logic rwr, output logic rto, output logic stable);
    logic accepted;
    accepted = 1'b0;
    req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      accepted = req_ready;
      tick();
    end
    req_valid = 1'b0;
    check("req_accept", accepted, 1);
    lat = 1;
    for (int i = 0; i < 300 && !rsp_valid; i++) begin
      tick();
      lat++;
    end
    check("rsp_valid_seen", rsp_valid, 1);
    rdata = rsp_rdata; resp = rsp_resp; rwr = rsp_write; rto = rsp_timeout;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!rsp_valid || rsp_rdata !== rdata || rsp_resp !== resp || req_ready !== 1'b0)
        stable = 1'b0;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("back_to_idle", {30'd0, req_ready, rsp_valid}, 32'h2);
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        rw, rt, st, seen;
    int          wc0;

    vecs[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 2'b00, 32'h0,        2'b00, 3};
    vecs[1] = '{1'b0, 32'h10,  32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 2'b00, 3};
    vecs[2] = '{1'b1, 32'h14,  32'h12345678, 4'h5, 2'b00, 32'h0,        2'b00, 3};
    vecs[3] = '{1'b0, 32'h14,  32'h0,        4'h0, 2'b00, 32'h00340078, 2'b00, 3};
    vecs[4] = '{1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 2'b10, 32'h0,        2'b10, 3};
    vecs[5] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 2'b11, 32'hA5A5A5A5, 2'b11, 3};
    vecs[6] = '{1'b0, 32'h20,  32'h0,        4'h0, 2'b00, 32'h0,        2'b00, 3};
    vecs[7] = '{1'b1, 32'h14,  32'hFFFFFFFF, 4'h2, 2'b01, 32'h0,        2'b01, 3};
    vecs[8] = '{1'b0, 32'h14,  32'h0,        4'h0, 2'b00, 32'h0034FF78, 2'b00, 3};

    for (int i = 0; i < 256; i++) mem[i] = '0;
    wr_count = 0; aw_hi = 0; w_hi = 0; ar_hi = 0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 1'b0;
    slave_clear();
    rst = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_resp}, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_valids_readies",
          {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    check("rst_awaddr", m_axi_awaddr, 0);
    check("rst_araddr", m_axi_araddr, 0);
    check("rst_wdata_wstrb", m_axi_wdata | {28'd0, m_axi_wstrb}, 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 9; v++) begin
      b_resp_cfg = vecs[v].slv_resp;
      r_resp_cfg = vecs[v].slv_resp;
      do_txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb, 0, lat, rd, rs, rw, rt, st);
      check($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rdata);
      check($sformatf("v%0d_resp", v), rs, vecs[v].exp_resp);
      check($sformatf("v%0d_write", v), rw, vecs[v].wr);
      check($sformatf("v%0d_timeout", v), rt, 0);
      check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
    end
    b_resp_cfg = 2'b00;
    r_resp_cfg = 2'b00;

    // awready 5 cycles late, wready immediate
    aw_dly = 5; aw_hi = 0; w_hi = 0; wc0 = wr_count;
    do_txn(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 0, lat, rd, rs, rw, rt, st);
    check("ooo_awvalid_cycles", aw_hi, 5);
    check("ooo_wvalid_cycles", w_hi, 1);
    check("ooo_slave_writes", wr_count - wc0, 1);
    check("ooo_latency", lat, 7);
    check("ooo_resp", rs, 0);
    aw_dly = 1;
    do_txn(1'b0, 32'h40, 32'h0, 4'h0, 0, lat, rd, rs, rw, rt, st);
    check("ooo_readback", rd, 32'hCAFEF00D);

    // Response held off for 10 cycles
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 10, lat, rd, rs, rw, rt, st);
    check("bp_stable", st, 1);
    check("bp_rdata", rd, 32'hDEADBEEF);
    check("bp_resp", rs, 0);

    // Reset while waiting for bvalid
    b_hold = 1'b1;
    req_write = 1'b1; req_addr = 32'h80; req_wdata = 32'h11111111; req_wstrb = 4'hF;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = m_axi_bready;
    end
    check("rstmid_in_wresp", seen, 1);
    rst = 1'b1;
    tick();
    check("rstmid_outputs",
          {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid, req_ready},
          32'h1);
    rst = 1'b0;
    b_hold = 1'b0;
    tick();
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, lat, rd, rs, rw, rt, st);
    check("rstmid_read_rdata", rd, 32'hDEADBEEF);
    check("rstmid_read_latency", lat, 3);

`ifdef AXIL_INITIATOR_TIMEOUT_EN
    // arready stuck low: watchdog of 16 cycles
    ar_stall = 1'b1; ar_hi = 0;
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, lat, rd, rs, rw, rt, st);
    check("to_arvalid_cycles", ar_hi, 16);
    check("to_resp", rs, 2'b10);
    check("to_timeout", rt, 1);
    check("to_rdata", rd, 0);
    check("to_latency", lat, 17);
    ar_stall = 1'b0;
    slave_clear();
    tick();
    do_txn(1'b0, 32'h14, 32'h0, 4'h0, 0, lat, rd, rs, rw, rt, st);
    check("to_after_rdata", rd, 32'h0034FF78);
    check("to_after_timeout", rt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/axil_initiator.md
# axil_initiator

AXI4-Lite master (initiator) that turns single-beat requests from a simple valid/ready command port into AXI4-Lite write or read transactions. It returns the write response, or the read data and response, on a matching response port. It sits between local control logic, such as a PCIe BAR decoder or debug sequencer, and any AXI4-Lite register or memory slave in the design. Only one transaction is outstanding at a time.

## Interface
- `TIMEOUT_CYCLES`, 1024: watchdog limit in clk cycles per transaction, used only when the timeout feature is compiled in. Must be ≥2. Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle and accepting a request.
- `req_write` in 1: 1 for write, 0 for read.
- `req_addr` in 32: byte address, passed through unmodified.
- `req_wdata` in 32: write data.
- `req_wstrb` in 4: write byte strobes.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_write` out 1: echo of `req_write`.
- `rsp_rdata` out 32: read data; 0 for writes.
- `rsp_resp` out 2: BRESP or RRESP, or 2'b10 on timeout.
- `rsp_timeout` out 1: transaction was abandoned by the watchdog.
- AXI4-Lite master ports:
  - `m_axi_awaddr` out 32
  - `m_axi_awvalid` out 1
  - `m_axi_awready` in 1
  - `m_axi_wdata` out 32
  - `m_axi_wstrb` out 4
  - `m_axi_wvalid` out 1
  - `m_axi_wready` in 1
  - `m_axi_bresp` in 2
  - `m_axi_bvalid` in 1
  - `m_axi_bready` out 1
  - `m_axi_araddr` out 32
  - `m_axi_arvalid` out 1
  - `m_axi_arready` in 1
  - `m_axi_rdata` in 32
  - `m_axi_rresp` in 2
  - `m_axi_rvalid` in 1
  - `m_axi_rready` out 1

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`, latch addr, wdata, wstrb and write flag. Go to WADDR if `req_write`, else RADDR.
  - WADDR: `awvalid` and `wvalid` are raised together. Each drops independently on its own handshake (`valid & ready`), and `aw` and `w` may complete in either order or in the same cycle. When both are done, go to WRESP.
  - WRESP: `bready`=1. On `bvalid`, capture `bresp`, set `rsp_rdata`=0, go to RSP.
  - RADDR: `arvalid`=1. On `arready`, drop `arvalid` and go to RDATA.
  - RDATA: `rready`=1. On `rvalid`, capture `rdata` and `rresp`, go to RSP.
  - RSP: `rsp_valid`=1 and held stable until `rsp_ready`, then go to IDLE.
- `bvalid` or `rvalid` arriving while the FSM is not in WRESP or RDATA respectively is ignored; it is not ready there. The slave must hold valid.
- All outputs are registered. AXI address and data outputs hold the latched request value for the whole transaction.
- `rst` from any state: FSM to IDLE, all valid and ready outputs to 0, and any in-flight transaction is dropped.

## Timing
- Reset values:
  - `req_ready`=1.
  - `rsp_valid`, `rsp_write`, `rsp_timeout`, and every `m_axi_*valid` and `*ready` are 0.
  - `rsp_rdata`, `rsp_resp`, and every `m_axi_*addr`, `*data` and `*strb` are 0.
- Request accepted at edge N. The AXI valids go high in cycle N+1.
- Write with zero-wait slave (ready high, bvalid one cycle after `w`):
  - WADDR lasts 1 cycle, WRESP lasts 1 cycle.
  - `rsp_valid` is high at N+3.
- Read with `arready` high and `rvalid` one cycle later: `rsp_valid` is high at N+3.
- `req_ready` is low from N+1 until the cycle after the `rsp_valid & rsp_ready` handshake.
- There is no back-to-back accept in RSP, so the minimum period between requests is 4 cycles.

## Configuration
- `AXIL_INITIATOR_TIMEOUT_EN` defined: watchdog behaviour.
  - A counter clears on leaving IDLE and increments each cycle in WADDR, WRESP, RADDR or RDATA.
  - On reaching `TIMEOUT_CYCLES`, all AXI valids and readies drop. This is a deliberate protocol abort for a hung slave.
  - The block then sets `rsp_resp`=2'b10, `rsp_timeout`=1 and `rsp_rdata`=0, and goes to RSP.
- `AXIL_INITIATOR_TIMEOUT_EN` undefined: no counter. The block waits indefinitely, and `rsp_timeout` is tied to 0.

## Test plan
- Write then read:
  - Stimulus: write addr 0x10, data 0xDEADBEEF, wstrb 0xF to a 256-word slave; then read addr 0x10.
  - Required response: write `rsp_resp`=0 with `rsp_rdata`=0; read `rsp_rdata`=0xDEADBEEF with `rsp_resp`=0.
- Zero-wait read latency:
  - Stimulus: accept a read at edge N with `arready` tied high and `rvalid` one cycle after the `ar` handshake.
  - Required response: `rsp_valid` is high at N+3.
- Out-of-order write channels:
  - Stimulus: `awready` delayed 5 cycles, `wready` immediate.
  - Required response: `wvalid` drops after 1 cycle, `awvalid` holds 5 cycles, exactly one slave write occurs, `rsp_valid` follows.
- Response backpressure:
  - Stimulus: hold `rsp_ready`=0 for 10 cycles.
  - Required response: `rsp_valid`, `rsp_rdata` and `rsp_resp` stay stable and `req_ready` stays 0; the block returns to IDLE one cycle after `rsp_ready`.
- Timeout (macro defined):
  - Stimulus: `TIMEOUT_CYCLES`=16, read with `arready` stuck at 0.
  - Required response: `arvalid` drops after 16 cycles, `rsp_resp`=2'b10, `rsp_timeout`=1.
- Reset mid-transaction:
  - Stimulus: `rst` asserted during WRESP with `bvalid`=0.
  - Required response: next cycle all valids and readies are 0 and `req_ready`=1; a following read completes normally.
